uart_rx_buffer: RTL and testbench

- Receive-side buffer placed directly downstream of the UART receiver.
- Captures each byte pulsed out of the receiver into a first-word-fall-through FIFO and presents it to the memory-mapped UART register block for CPU reads.
- Tracks overflow and generates a receive interrupt on a fill threshold or on a character-idle timeout.
- The timeout is measured in 16x oversampling ticks, so it scales with the baud rate.

---
 rtl/uart_defs_pkg.sv | 14 +
 rtl/uart_rx_buffer_fifo.sv | 62 ++++++
 rtl/uart_rx_buffer.sv | 90 +++++++++
 tb/tb_uart_rx_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// Shared UART constants used by the receive buffer and the register block.
// Defaults here set the FIFO depth, irq threshold and character-idle timeout.
package uart_defs;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int RX_FIFO_ADDR_WIDTH = 4;
  localparam int RX_FIFO_THRESHOLD  = 8;
  // Four 8N1 character times measured in 16x oversampling ticks.
  localparam int RX_TIMEOUT_TICKS   = 640;
  localparam int TIMEOUT_CNT_WIDTH  = 16;

  typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_buffer_fifo.sv
// First-word-fall-through synchronous FIFO with an explicit occupancy count.
// A write into a full FIFO is accepted only when a read retires an entry in the same cycle.
module sync_fifo
  import uart_defs::*;
#(
  parameter int WIDTH      = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = RX_FIFO_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   count_next,
  output logic                  wr_accept,
  output logic                  rd_accept
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign rd_accept = rd_en & ~empty;
  assign wr_accept = wr_en & (~full | rd_accept);
  assign rd_data   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + (ADDR_WIDTH+1)'(1);
      2'b01:   count_next = count - (ADDR_WIDTH+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_accept) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count <= count_next;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clock) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side buffer: captures receiver bytes into a FWFT FIFO and raises a
// registered interrupt on fill threshold or on a character-idle timeout.
module uart_rx_buffer
  import uart_defs::*;
#(
  parameter int ADDR_WIDTH    = RX_FIFO_ADDR_WIDTH,
  parameter int THRESHOLD     = RX_FIFO_THRESHOLD,
  parameter int TIMEOUT_TICKS = RX_TIMEOUT_TICKS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       uart_tick_16x,
  input  logic [UART_DATA_WIDTH-1:0] rx_data,
  input  logic                       rx_valid,
  input  logic                       rd_en,
  input  logic                       clr_overflow,
  output logic [UART_DATA_WIDTH-1:0] rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [ADDR_WIDTH:0]        count,
  output logic                       overflow,
  output logic                       irq
);

  localparam logic [TIMEOUT_CNT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_CNT_WIDTH'(TIMEOUT_TICKS);
  localparam logic [ADDR_WIDTH:0]          THRESH_COUNT  = (ADDR_WIDTH+1)'(THRESHOLD);

  logic [ADDR_WIDTH:0]            count_next;
  logic                           wr_accept;
  logic                           rd_accept;
  logic                           drop;
  logic [TIMEOUT_CNT_WIDTH-1:0]   timeout_cnt;
  logic [TIMEOUT_CNT_WIDTH-1:0]   timeout_cnt_next;
  logic                           timeout_flag;
  logic                           timeout_flag_next;
  logic                           timeout_clear;

  sync_fifo #(
    .WIDTH      (UART_DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (rx_valid),
    .wr_data    (rx_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .count_next (count_next),
    .wr_accept  (wr_accept),
    .rd_accept  (rd_accept)
  );

  assign drop = rx_valid & ~wr_accept;

  // Any FIFO activity, or nothing pending, restarts the idle measurement.
  always_comb begin
    timeout_clear     = wr_accept | rd_accept | empty;
    timeout_cnt_next  = timeout_cnt;
    timeout_flag_next = timeout_flag;
    if (timeout_clear) begin
      timeout_cnt_next  = '0;
      timeout_flag_next = 1'b0;
    end else begin
      if (uart_tick_16x && (timeout_cnt < TIMEOUT_LIMIT))
        timeout_cnt_next = timeout_cnt + TIMEOUT_CNT_WIDTH'(1);
      if (timeout_cnt == TIMEOUT_LIMIT)
        timeout_flag_next = 1'b1;
    end
  end

  // A fresh drop outranks a coincident clear so no loss goes unreported.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow     <= 1'b0;
      timeout_cnt  <= '0;
      timeout_flag <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
      timeout_cnt  <= timeout_cnt_next;
      timeout_flag <= timeout_flag_next;
      irq          <= (count_next >= THRESH_COUNT) | timeout_flag_next;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: a queue-based reference model checked
// every cycle, plus directed sequences with literal expected values.
module tb_uart_rx_buffer;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;
  localparam int TOUT   = 640;

  logic       clock;
  logic       reset;
  logic       uart_tick_16x;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rd_en;
  logic       clr_overflow;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       irq;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  bit  m_ovf      = 0;
  bit  m_flag     = 0;
  bit  m_irq      = 0;
  int  m_idle     = 0;
  bit  model_live = 0;

  uart_rx_buffer dut (
    .clock         (clock),
    .reset         (reset),
    .uart_tick_16x (uart_tick_16x),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rd_en         (rd_en),
    .clr_overflow  (clr_overflow),
    .rd_data       (rd_data),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .overflow      (overflow),
    .irq           (irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: FIFO as a queue, timeout as ticks seen since the last activity.
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_ovf  = 0;
      m_flag = 0;
      m_idle = 0;
      m_irq  = 0;
      model_live = 1;
    end else if (model_live) begin
      bit was_empty, rd_ok, wr_ok;
      was_empty = (mq.size() == 0);
      rd_ok = rd_en && !was_empty;
      wr_ok = rx_valid && ((mq.size() < DEPTH) || rd_ok);
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) mq.push_back(rx_data);
      if (rx_valid && !wr_ok) m_ovf = 1;
      else if (clr_overflow)  m_ovf = 0;
      if (rd_ok || wr_ok || was_empty) begin
        m_idle = 0;
        m_flag = 0;
      end else begin
        if (m_idle >= TOUT) m_flag = 1;
        if (uart_tick_16x && m_idle < TOUT) m_idle++;
      end
      m_irq = (mq.size() >= THRESH) || m_flag;
    end
  end

  always @(negedge clock) begin
    if (model_live && !reset) begin
      checkOutput("model_count", count, mq.size());
      checkOutput("model_empty", empty, mq.size() == 0);
      checkOutput("model_full", full, mq.size() == DEPTH);
      checkOutput("model_overflow", overflow, m_ovf);
      checkOutput("model_irq", irq, m_irq);
      if (mq.size() != 0) checkOutput("model_rd_data", rd_data, mq[0]);
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r,
                               input logic c, input logic t, input logic rst);
    rx_valid      = v;
    rx_data       = d;
    rd_en         = r;
    clr_overflow  = c;
    uart_tick_16x = t;
    reset         = rst;
    @(posedge clock);
    #1;
    rx_valid      = 1'b0;
    rd_en         = 1'b0;
    clr_overflow  = 1'b0;
    uart_tick_16x = 1'b0;
    reset         = 1'b0;
  endtask

  task automatic writeByte(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic readExpect(input string name, input logic [7:0] exp);
    checkOutput(name, rd_data, exp);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rx_data = 8'h00;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_irq", irq, 0);

    $display("[TB] basic ordering");
    writeByte(8'h41); writeByte(8'h42); writeByte(8'h43);
    checkOutput("abc_count", count, 3);
    checkOutput("abc_head", rd_data, 8'h41);
    readExpect("abc_rd0", 8'h41);
    readExpect("abc_rd1", 8'h42);
    readExpect("abc_rd2", 8'h43);
    checkOutput("abc_empty", empty, 1);
    checkOutput("abc_count0", count, 0);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 16; i++) writeByte(8'(i));
    checkOutput("fill_full", full, 1);
    checkOutput("fill_count", count, 16);
    writeByte(8'hFF);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_count", count, 16);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf_set_wins", overflow, 1);
    for (int i = 0; i < 16; i++) readExpect("fill_rd", 8'(i));
    checkOutput("fill_drained", empty, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf_clear", overflow, 0);

    $display("[TB] read+write while full, pointer wrap");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) writeByte(8'(8'h20 + r*16 + i));
      applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("rw_full_ovf", overflow, 0);
      checkOutput("rw_full_count", count, 16);
      for (int i = 1; i < 16; i++) readExpect("wrap_rd", 8'(8'h20 + r*16 + i));
      readExpect("wrap_last_aa", 8'hAA);
      checkOutput("wrap_empty", empty, 1);
    end

    $display("[TB] threshold irq");
    for (int i = 0; i < 7; i++) writeByte(8'(8'h50 + i));
    checkOutput("thr_7_irq", irq, 0);
    writeByte(8'h57);
    checkOutput("thr_8_irq", irq, 1);
    readExpect("thr_rd", 8'h50);
    checkOutput("thr_back7_irq", irq, 0);
    for (int i = 1; i < 8; i++) readExpect("thr_drain", 8'(8'h50 + i));

    $display("[TB] idle timeout irq");
    writeByte(8'h5A);
    ticks(639);
    checkOutput("to_639_irq", irq, 0);
    ticks(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("to_640_irq", irq, 1);
    readExpect("to_rd", 8'h5A);
    checkOutput("to_rd_irq", irq, 0);
    checkOutput("to_rd_empty", empty, 1);
    writeByte(8'h61);
    ticks(600);
    writeByte(8'h62);
    ticks(639);
    checkOutput("to_restart_irq", irq, 0);
    ticks(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("to_restart_fire", irq, 1);
    readExpect("to_rd_61", 8'h61);
    readExpect("to_rd_62", 8'h62);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 16; i++) writeByte(8'(8'h70 + i));
    writeByte(8'hFE);
    for (int i = 0; i < 11; i++) readExpect("mid_rd", 8'(8'h70 + i));
    checkOutput("mid_count5", count, 5);
    checkOutput("mid_ovf", overflow, 1);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("mid_rst_count", count, 0);
    checkOutput("mid_rst_empty", empty, 1);
    checkOutput("mid_rst_ovf", overflow, 0);
    checkOutput("mid_rst_irq", irq, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("underflow_count", count, 0);
    checkOutput("underflow_empty", empty, 1);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rw_empty_count", count, 1);
    checkOutput("rw_empty_head", rd_data, 8'h99);
    readExpect("rw_empty_rd", 8'h99);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
